// File: rtl/wb_fft_drain.sv
// Writeback consumer: register write is same-cycle, FFT samples go through a show-ahead FIFO (visible one cycle after push).
// Backpressure: stall_out holds the pipeline while the FIFO is full; the FFT side drains over fft_valid/fft_ready.

module wb_fft_drain_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module wb_fft_drain #(
    parameter int DATAW     = 16,
    parameter int ADDRW     = 32,
    parameter int REGADDRW  = 5,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic                    fft_wr_en_in,
    input  logic                    reg_wr_en_in,
    input  logic [ADDRW-1:0]        addr_in,
    input  logic [DATAW-1:0]        data_in,
    output logic                    stall_out,
    output logic                    reg_wr_en,
    output logic [REGADDRW-1:0]     reg_wr_addr,
    output logic [DATAW-1:0]        reg_wr_data,
    output logic                    fft_valid,
    input  logic                    fft_ready,
    output logic [ADDRW-1:0]        fft_addr,
    output logic [DATAW-1:0]        fft_data,
    output logic                    fft_start,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int FCW = $clog2(FRAME_LEN);

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
    } sample_t;

    logic           full;
    logic           push_req;
    logic           push;
    logic           pop;
    sample_t        push_dat;
    sample_t        head_dat;
    logic [FCW-1:0] frame_cnt;

    // Stall depends only on registered occupancy, so a same-cycle pop never releases it.
    assign full      = (fifo_count == CW'(DEPTH));
    assign push_req  = valid_in & fft_wr_en_in;
    assign stall_out = push_req & full;
    assign push      = push_req & ~full;
    assign pop       = fft_valid & fft_ready;

    assign reg_wr_en   = valid_in & reg_wr_en_in & ~stall_out;
    assign reg_wr_addr = addr_in[REGADDRW-1:0];
    assign reg_wr_data = data_in;

    assign push_dat.addr = addr_in;
    assign push_dat.data = data_in;

    wb_fft_drain_fifo #(
        .WIDTH (ADDRW + DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign fft_valid = (fifo_count != '0);
    assign fft_addr  = head_dat.addr;
    assign fft_data  = head_dat.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            fft_start <= 1'b0;
        end else begin
            fft_start <= pop && (frame_cnt == FCW'(FRAME_LEN - 1));
            if (pop) frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_fft_drain.sv
// Bench for wb_fft_drain: directed stimulus with a negedge monitor that scores every handshake against a queue model.
module tb_wb_fft_drain;
    localparam int DATAW     = 16;
    localparam int ADDRW     = 32;
    localparam int REGADDRW  = 5;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0, fft_wr_en_in = 1'b0, reg_wr_en_in = 1'b0, fft_ready = 1'b0;
    logic [ADDRW-1:0] addr_in = '0;
    logic [DATAW-1:0] data_in = '0;
    logic stall_out, reg_wr_en, fft_valid, fft_start;
    logic [REGADDRW-1:0] reg_wr_addr;
    logic [DATAW-1:0] reg_wr_data, fft_data;
    logic [ADDRW-1:0] fft_addr;
    logic [$clog2(DEPTH):0] fifo_count;

    wb_fft_drain #(
        .DATAW(DATAW), .ADDRW(ADDRW), .REGADDRW(REGADDRW), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .fft_wr_en_in(fft_wr_en_in),
        .reg_wr_en_in(reg_wr_en_in), .addr_in(addr_in), .data_in(data_in),
        .stall_out(stall_out), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .fft_valid(fft_valid), .fft_ready(fft_ready),
        .fft_addr(fft_addr), .fft_data(fft_data), .fft_start(fft_start), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [ADDRW-1:0] a;
        logic [DATAW-1:0] d;
    } smp_t;

    smp_t q[$];
    int   m_cnt = 0, fcnt = 0;
    logic exp_start = 1'b0;
    int   n_pops = 0, n_start = 0, n_reg = 0;

    // Inputs change just after posedge, so at negedge they show what the next edge will act on.
    always @(negedge clk) begin : monitor
        logic exp_stall, exp_reg, pop, push;
        smp_t h;
        chk("fft_start", fft_start, exp_start);
        if (fft_start) n_start++;
        chk("fifo_count", fifo_count, m_cnt);
        chk("fft_valid", fft_valid, m_cnt != 0);
        exp_stall = valid_in && fft_wr_en_in && (m_cnt == DEPTH);
        chk("stall_out", stall_out, exp_stall);
        exp_reg = valid_in && reg_wr_en_in && !exp_stall;
        chk("reg_wr_en", reg_wr_en, exp_reg);
        if (reg_wr_en) n_reg++;
        if (exp_reg) begin
            chk("reg_wr_addr", reg_wr_addr, addr_in[REGADDRW-1:0]);
            chk("reg_wr_data", reg_wr_data, data_in);
        end
        if (rst) begin
            q.delete();
            m_cnt = 0;
            fcnt = 0;
            exp_start = 1'b0;
        end else begin
            pop  = (m_cnt != 0) && fft_ready;
            push = valid_in && fft_wr_en_in && !exp_stall;
            exp_start = 1'b0;
            if (pop) begin
                h = q.pop_front();
                chk("fft_addr", fft_addr, h.a);
                chk("fft_data", fft_data, h.d);
                n_pops++;
                exp_start = (fcnt == FRAME_LEN - 1);
                fcnt = (fcnt + 1) % FRAME_LEN;
            end
            if (push) q.push_back({addr_in, data_in});
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic fe, input logic re,
                         input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
        valid_in = v; fft_wr_en_in = fe; reg_wr_en_in = re; addr_in = a; data_in = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain(input int budget);
        fft_ready = 1'b1;
        for (int i = 0; i < budget && fifo_count != 0; i++) step();
        chk("drain_timeout", fifo_count, 0);
        fft_ready = 1'b0;
    endtask

    int reg0, st0, p0;

    initial begin
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", fft_valid, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_start", fft_start, 0);

        // Register-only beat commits in the same cycle.
        drive(1'b1, 1'b0, 1'b1, 32'h3, 16'h1234);
        #1;
        chk("reg_only_en", reg_wr_en, 1);
        chk("reg_only_addr", reg_wr_addr, 5'd3);
        chk("reg_only_data", reg_wr_data, 16'h1234);
        step();
        idle();
        #1;
        chk("reg_only_count", fifo_count, 0);

        // Fill with the FFT side blocked; fifth beat must stall.
        fft_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h100 + i, 16'hA000 + 16'(i));
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h104, 16'hA004);
        #1;
        chk("full_stall", stall_out, 1);
        chk("full_count", fifo_count, 4);
        step();
        chk("held_stall", stall_out, 1);
        fft_ready = 1'b1;
        step();
        fft_ready = 1'b0;
        chk("release_stall", stall_out, 0);
        chk("release_count", fifo_count, 3);
        step();
        idle();
        #1;
        chk("refill_count", fifo_count, 4);
        chk("pops_after_one", n_pops, 1);

        // Dual-write beat while full commits only once, on acceptance.
        reg0 = n_reg;
        drive(1'b1, 1'b1, 1'b1, 32'h7, 16'hBEEF);
        #1;
        chk("dual_stall", stall_out, 1);
        chk("dual_reg_blocked", reg_wr_en, 0);
        step();
        chk("dual_reg_blocked2", reg_wr_en, 0);
        fft_ready = 1'b1;
        step();
        fft_ready = 1'b0;
        chk("dual_release", stall_out, 0);
        chk("dual_reg_commit", reg_wr_en, 1);
        step();
        idle();
        #1;
        chk("dual_reg_once", n_reg - reg0, 1);
        chk("dual_count", fifo_count, 4);
        drain(20);
        chk("drain_pops", n_pops, 6);
        chk("drain_starts", n_start, 1);

        // Streaming with ready held high: one in, one out per cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_count", fifo_count, 0);
        st0 = n_start;
        p0 = n_pops;
        fft_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h200 + i, 16'hC000 + 16'(i));
            step();
            chk("stream_le1", fifo_count <= 1, 1);
            chk("stream_nostall", stall_out, 0);
            chk("stream_start", fft_start, i == 4);
        end
        idle();
        step();
        chk("stream_empty", fifo_count, 0);
        chk("stream_pops", n_pops - p0, 6);
        chk("stream_starts", n_start - st0, 1);
        drive(1'b1, 1'b1, 1'b0, 32'h206, 16'hC006);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h207, 16'hC007);
        step();
        idle();
        step();
        chk("frame2_start", fft_start, 1);
        step();
        chk("frame2_single", fft_start, 0);
        chk("frame2_starts", n_start - st0, 2);

        // Partial frame plus queued samples are discarded by reset.
        drive(1'b1, 1'b1, 1'b0, 32'h2F0, 16'h1111);
        step();
        idle();
        step();
        fft_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h300 + i, 16'h4400 + 16'(i));
            step();
        end
        idle();
        #1;
        chk("pre_rst_count", fifo_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", fft_valid, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_start", fft_start, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h310, 16'h5510);
        step();
        idle();
        #1;
        chk("new_head_valid", fft_valid, 1);
        chk("new_head_addr", fft_addr, 32'h310);
        chk("new_head_data", fft_data, 16'h5510);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h310 + i, 16'h5510 + 16'(i));
            step();
        end
        idle();
        for (int k = 1; k <= 4; k++) begin
            fft_ready = 1'b1;
            step();
            fft_ready = 1'b0;
            chk("restart_start", fft_start, k == 4);
        end
        step();
        chk("sb_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
